// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// mips_pkg : shared MIPS opcodes, MEM-stage FSM states, access-size helpers
// Rev 1.0
// ============================================================================
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

  typedef enum logic [1:0] {
    SZ_NONE = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_WORD = 2'd3
  } mem_size_t;

  function automatic mem_size_t op_size(input logic [5:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: op_size = SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: op_size = SZ_HALF;
      OP_LW, OP_SW:         op_size = SZ_WORD;
      default:              op_size = SZ_NONE;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
// mem_access_unit_if : pipeline-side and data-memory-side signals of the MEM stage
// Rev 1.0
// ============================================================================
interface mem_access_unit_if;
  logic [5:0]  MEM_Opcode;
  logic [31:0] MEM_ALU_RESULT;
  logic [31:0] MEM_WR_DATA;
  logic [31:0] MEM_RD_DATA;
  logic        MEM_STALL;
  logic        MEM_ALIGN_ERR;
  logic        MEM_BUS_ERR;
  logic        DM_REQ;
  logic        DM_WE;
  logic [31:0] DM_ADDR;
  logic [3:0]  DM_BE;
  logic [31:0] DM_WDATA;
  logic        DM_ACK;
  logic [31:0] DM_RDATA;

  // master = the load/store unit, slave = pipeline plus data memory
  modport master (
    input  MEM_Opcode, MEM_ALU_RESULT, MEM_WR_DATA, DM_ACK, DM_RDATA,
    output MEM_RD_DATA, MEM_STALL, MEM_ALIGN_ERR, MEM_BUS_ERR,
           DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA
  );

  modport slave (
    output MEM_Opcode, MEM_ALU_RESULT, MEM_WR_DATA, DM_ACK, DM_RDATA,
    input  MEM_RD_DATA, MEM_STALL, MEM_ALIGN_ERR, MEM_BUS_ERR,
           DM_REQ, DM_WE, DM_ADDR, DM_BE, DM_WDATA
  );
endinterface
`default_nettype wire

// File: rtl/mem_load_align.sv
`default_nettype none
// ============================================================================
// mem_load_align : selects the byte/halfword lane of a read word and extends it
// Rev 1.0
// ============================================================================
module mem_load_align
  import mips_pkg::*;
(
  input  wire logic [31:0] rdata_i,
  input  wire logic [1:0]  off_i,
  input  wire logic [5:0]  op_i,
  output logic      [31:0] data_o
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = rdata_i[{off_i, 3'b000} +: 8];
    w_half = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (op_i)
      OP_LB:   data_o = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  data_o = {24'b0, w_byte};
      OP_LH:   data_o = {{16{w_half[15]}}, w_half};
      OP_LHU:  data_o = {16'b0, w_half};
      default: data_o = rdata_i;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// mem_access_unit : MEM-stage load/store engine with req/ack memory handshake
// Rev 1.0
// ============================================================================
module mem_access_unit
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
)(
  input  wire logic         CLK,
  input  wire logic         RESET,
  mem_access_unit_if.master bus
);

  mem_state_t  state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic        err_q, err_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_q, rd_d;
  logic [31:0] cnt_q, cnt_d;
  logic [3:0]  be_q, be_d;
  logic [5:0]  op_q, op_d;
  logic [1:0]  off_q, off_d;

  mem_size_t   w_size;
  logic        w_store, w_aligned, w_start, w_timeout, w_op_is_load;
  logic [1:0]  w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_load_data;

  assign w_off = bus.MEM_ALU_RESULT[1:0];

  always_comb begin
    w_size    = op_size(bus.MEM_Opcode);
    w_store   = op_is_store(bus.MEM_Opcode);
    w_be      = 4'b1111;
    w_wdata   = bus.MEM_WR_DATA;
    w_aligned = 1'b1;
    case (w_size)
      SZ_BYTE: begin
        w_wdata = {4{bus.MEM_WR_DATA[7:0]}};
        if (w_store) w_be = 4'b0001 << w_off;
      end
      SZ_HALF: begin
        w_aligned = ~w_off[0];
        w_wdata   = {2{bus.MEM_WR_DATA[15:0]}};
        if (w_store) w_be = w_off[1] ? 4'b1100 : 4'b0011;
      end
      SZ_WORD: w_aligned = (w_off == 2'b00);
      default: ;
    endcase
  end

  assign w_start      = (state_q == IDLE) && (w_size != SZ_NONE) && w_aligned;
  assign w_timeout    = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);
  assign w_op_is_load = (op_size(op_q) != SZ_NONE) && !op_is_store(op_q);

  mem_load_align u_load_align (
    .rdata_i (bus.DM_RDATA),
    .off_i   (off_q),
    .op_i    (op_q),
    .data_o  (w_load_data)
  );

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    be_d    = be_q;
    op_d    = op_q;
    off_d   = off_q;
    case (state_q)
      IDLE: begin
        if (w_start) begin
          state_d = BUSY;
          req_d   = 1'b1;
          we_d    = w_store;
          addr_d  = {bus.MEM_ALU_RESULT[31:2], 2'b00};
          be_d    = w_be;
          wdata_d = w_wdata;
          op_d    = bus.MEM_Opcode;
          off_d   = w_off;
          cnt_d   = 32'd0;
          err_d   = 1'b0;
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 32'd1;
        // ACK wins over a timeout landing on the same cycle
        if (bus.DM_ACK) begin
          state_d = DONE;
          req_d   = 1'b0;
          if (w_op_is_load) rd_d = w_load_data;
        end else if (w_timeout) begin
          state_d = DONE;
          req_d   = 1'b0;
          err_d   = 1'b1;
          if (w_op_is_load) rd_d = 32'd0;
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 32'd0;
      cnt_q   <= 32'd0;
      be_q    <= 4'd0;
      op_q    <= 6'd0;
      off_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      be_q    <= be_d;
      op_q    <= op_d;
      off_q   <= off_d;
    end
  end

  assign bus.MEM_RD_DATA   = rd_q;
  assign bus.MEM_STALL     = w_start || (state_q == BUSY);
  assign bus.MEM_ALIGN_ERR = (state_q == IDLE) && (w_size != SZ_NONE) && !w_aligned;
  assign bus.MEM_BUS_ERR   = (state_q == DONE) && err_q;
  assign bus.DM_REQ        = req_q;
  assign bus.DM_WE         = we_q;
  assign bus.DM_ADDR       = addr_q;
  assign bus.DM_BE         = be_q;
  assign bus.DM_WDATA      = wdata_q;

endmodule
`default_nettype wire
